// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared types and constants for the spi_slave block.  Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Encoded as {cpol, cpha}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  localparam int SPI_SYNC_STAGES = 2;

  function automatic logic mode_cpol(input spi_mode_t m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_t m);
    return m[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sync : generic N-stage synchronizer, async active-low reset.  Rev 1.0
// ---------------------------------------------------------------------------
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave : oversampled SPI slave, all CPOL/CPHA modes, LSB-first duplex.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              load,
  input  logic [DATA_W-1:0] data_to_write,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] data_read,
  output logic              rx_valid,
  output logic              busy
);

  localparam int               CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

  logic w_sclk, w_cs_n, w_mosi;

  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(sclk), .o_sync(w_sclk)
  );
  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .i_async(cs_n), .o_sync(w_cs_n)
  );
  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(mosi), .o_sync(w_mosi)
  );

  spi_state_t        state_q,     state_d;
  spi_mode_t         mode_q,      mode_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_n_prev_q, cs_n_prev_d;
  logic [DATA_W-1:0] tx_buf_q,    tx_buf_d;
  logic [DATA_W-1:0] tx_sh_q,     tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q,     rx_sh_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic              miso_q,      miso_d;
  logic [DATA_W-1:0] data_read_q, data_read_d;
  logic              rx_valid_q,  rx_valid_d;
  logic              busy_q,      busy_d;

  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_shift, w_cs_fall;

  assign w_sclk_rise = w_sclk & ~sclk_prev_q;
  assign w_sclk_fall = ~w_sclk & sclk_prev_q;
  assign w_lead      = mode_cpol(mode_q) ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = mode_cpol(mode_q) ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = mode_cpha(mode_q) ? w_trail : w_lead;
  assign w_shift     = mode_cpha(mode_q) ? w_lead  : w_trail;
  assign w_cs_fall   = ~w_cs_n & cs_n_prev_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sclk_prev_d = w_sclk;
    cs_n_prev_d = w_cs_n;
    tx_buf_d    = load ? data_to_write : tx_buf_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    data_read_d = data_read_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        busy_d = 1'b0;
        if (w_cs_fall) begin
          state_d   = ACTIVE;
          busy_d    = 1'b1;
          mode_d    = spi_mode_t'({cpol, cpha});
          tx_sh_d   = tx_buf_q;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          miso_d    = cpha ? 1'b0 : tx_buf_q[0];
        end
      end

      ACTIVE: begin
        if (w_shift) begin
          if (mode_cpha(mode_q)) begin
            miso_d  = tx_sh_q[0];
            tx_sh_d = tx_sh_q >> 1;
          end else if (bit_cnt_q != '0) begin
            miso_d  = tx_sh_q[1];
            tx_sh_d = tx_sh_q >> 1;
          end else begin
            // Trailing edge right after a word wrap: bit 0 of the freshly
            // reloaded word must be presented, not shifted away.
            miso_d = tx_sh_q[0];
          end
        end

        if (w_sample) begin
          rx_sh_d[bit_cnt_q] = w_mosi;
          if (bit_cnt_q == c_last_bit) begin
            data_read_d = rx_sh_d;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            tx_sh_d     = tx_buf_q;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end

        // Deselect wins over everything except a word completing this cycle.
        if (w_cs_n) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE0;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      tx_buf_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      data_read_q <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sclk_prev_q <= sclk_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      tx_buf_q    <= tx_buf_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      data_read_q <= data_read_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign miso      = miso_q;
  assign data_read = data_read_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_slave : scoreboard bench for spi_slave acting as an SPI master.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_slave;

  localparam int H = 6;  // SCLK half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpol, cpha, load;
  logic [7:0] data_to_write;
  logic       cs_n, sclk, mosi;
  logic       miso;
  logic [7:0] data_read;
  logic       rx_valid, busy;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         rx_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .load(load),
    .data_to_write(data_to_write), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .data_read(data_read), .rx_valid(rx_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard consumer: every received word must match the oldest pushed one.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      logic [7:0] e;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        check("rx_extra", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", data_read, e);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    load = 1'b1;
    data_to_write = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic shift_bits(input logic cp, input logic ch, input logic [15:0] mw,
                            input int nbits, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!ch) begin
        mosi = mw[i];
        wait_clk(H);
        sclk = ~cp;
        cap[i] = miso;
        wait_clk(H);
        sclk = cp;
      end else begin
        sclk = ~cp;
        mosi = mw[i];
        wait_clk(H);
        sclk = cp;
        cap[i] = miso;
        wait_clk(H);
      end
    end
  endtask

  task automatic start_cs(input logic cp, input logic ch);
    cpol = cp;
    cpha = ch;
    sclk = cp;
    wait_clk(4);
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic end_cs();
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_frame(input logic cp, input logic ch, input logic [7:0] mw,
                          input logic [7:0] sw, input string tag);
    logic [15:0] cap;
    int          rx_before;
    do_load(sw);
    rx_before = rx_cnt;
    exp_q.push_back(mw);
    start_cs(cp, ch);
    shift_bits(cp, ch, {8'h00, mw}, 8, cap);
    end_cs();
    check({tag, "_miso"}, cap[7:0], sw);
    check({tag, "_pulses"}, rx_cnt - rx_before, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [15:0] cap;
    int          rx_before;

    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; load = 1'b0; data_to_write = '0;
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check("rst_miso", miso, 0);
    check("rst_data_read", data_read, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);

    do_frame(1'b0, 1'b0, 8'hBA, 8'hA5, "mode0");
    do_frame(1'b1, 1'b0, 8'hA7, 8'hC2, "mode2");
    do_frame(1'b0, 1'b1, 8'hA4, 8'hB5, "mode1");
    do_frame(1'b1, 1'b1, 8'hBA, 8'h94, "mode3");

    // Abort after 4 bits: nothing reaches the scoreboard
    rx_before = rx_cnt;
    start_cs(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 16'h003C, 4, cap);
    check("abort_busy_mid", busy, 1);
    cs_n = 1'b1;
    wait_clk(3);
    check("abort_busy", busy, 0);
    check("abort_miso", miso, 0);
    wait_clk(10);
    check("abort_data_read", data_read, 8'hBA);
    check("abort_pulses", rx_cnt - rx_before, 0);

    // Back-to-back words under one chip select, reloading mid-word
    do_load(8'h5C);
    rx_before = rx_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    start_cs(1'b0, 1'b0);
    fork
      shift_bits(1'b0, 1'b0, 16'hC33C, 16, cap);
      begin
        wait_clk(20);
        do_load(8'h11);
        wait_clk(30);
        do_load(8'h22);
      end
    join
    end_cs();
    check("b2b_word0_miso", cap[7:0], 8'h5C);
    check("b2b_word1_miso", cap[15:8], 8'h22);
    check("b2b_pulses", rx_cnt - rx_before, 2);

    // Reset in the middle of a frame
    do_load(8'h77);
    start_cs(1'b0, 1'b0);
    shift_bits(1'b0, 1'b0, 16'h00FF, 5, cap);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_data_read", data_read, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
    do_frame(1'b0, 1'b0, 8'h5A, 8'h3E, "post_rst");

    wait_clk(10);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
